// File: rtl/tone_rom_player.sv
// Tone ROM address sequencer and stereo sample streamer for the I2S transmit path.
// Steps the ROM address, registers each returned word and offers it downstream with a
// valid/ready handshake. Wraps after LAST_ADDR so the tone loops, and counts completed loops.
// Optional feature: define TONE_ROM_PLAYER_GAIN_EN to add gain_shift_i, an arithmetic
// right shift applied to each 16-bit channel half as the word is fetched.
module tone_rom_player #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned LAST_ADDR      = 127,
  parameter int unsigned WRAP_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  output logic [ADDR_WIDTH-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0]     rom_q_i,
  output logic [DATA_WIDTH-1:0]     sample_o,
  output logic                      sample_valid_o,
  input  logic                      sample_ready_i,
`ifdef TONE_ROM_PLAYER_GAIN_EN
  input  logic [3:0]                gain_shift_i,
`endif
  output logic [WRAP_CNT_WIDTH-1:0] wrap_count_o,
  output logic                      busy_o
);

  localparam int unsigned HalfW = DATA_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [WRAP_CNT_WIDTH-1:0] WrapMax = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic [WRAP_CNT_WIDTH-1:0] wrap_q, wrap_d;
  logic                      busy_q;
  logic                      handshake;
  logic [DATA_WIDTH-1:0]     fetch_word;

`ifdef TONE_ROM_PLAYER_GAIN_EN
  logic signed [HalfW-1:0] left_s, right_s;

  // Attenuate each channel independently, keeping its sign.
  always_comb begin
    left_s     = $signed(rom_q_i[DATA_WIDTH-1 -: HalfW]) >>> gain_shift_i;
    right_s    = $signed(rom_q_i[HalfW-1:0]) >>> gain_shift_i;
    fetch_word = {left_s, right_s};
  end
`else
  assign fetch_word = rom_q_i;
`endif

  assign handshake = valid_q & sample_ready_i;

  // Next-state logic: one fetch cycle, then hold the sample until it is accepted.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    wrap_d   = wrap_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          addr_d  = '0;
          wrap_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        sample_d = fetch_word;
        valid_d  = 1'b1;
        state_d  = StPresent;
      end
      StPresent: begin
        // Valid is only ever retired by a handshake, regardless of enable_i.
        if (handshake) begin
          valid_d = 1'b0;
          if (addr_q == LastAddr) begin
            addr_d = '0;
            if (wrap_q != WrapMax) begin
              wrap_d = wrap_q + 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
          state_d = enable_i ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears valid immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign rom_addr_o     = addr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign wrap_count_o   = wrap_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_tone_rom_player.sv
// Self-checking bench for tone_rom_player: a short loop (LAST_ADDR=3) and a narrow loop
// counter so wrapping and saturation are reached quickly.
module tb_tone_rom_player;

  localparam int unsigned Last  = 3;
  localparam int unsigned Loop  = Last + 1;
  localparam int unsigned WrapW = 3;
  localparam int unsigned WrapM = (1 << WrapW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             ready = 1'b0;
  logic [6:0]       rom_addr;
  logic [31:0]      rom_q;
  logic [31:0]      sample;
  logic             valid;
  logic [WrapW-1:0] wrap_count;
  logic             busy;
  logic             force_en = 1'b0;
  logic [31:0]      force_val = 32'h0;
`ifdef TONE_ROM_PLAYER_GAIN_EN
  logic [3:0]       gain = 4'd0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_rom_player #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (7),
    .LAST_ADDR     (Last),
    .WRAP_CNT_WIDTH(WrapW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (en),
    .rom_addr_o    (rom_addr),
    .rom_q_i       (rom_q),
    .sample_o      (sample),
    .sample_valid_o(valid),
    .sample_ready_i(ready),
`ifdef TONE_ROM_PLAYER_GAIN_EN
    .gain_shift_i  (gain),
`endif
    .wrap_count_o  (wrap_count),
    .busy_o        (busy)
  );

  function automatic logic [31:0] rom_word(input int unsigned a);
    return {16'hA000 + 16'(a), 16'h1000 + 16'(a)};
  endfunction

  // ROM model; force_en lets the bench drive arbitrary words (noise or gain vectors).
  always_comb begin
    rom_q = force_en ? force_val : rom_word(32'(rom_addr));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        vld;
    logic [31:0] smp;
    logic [6:0]  addr;
    logic [2:0]  wrap;
    logic        busy;
  } vec_t;

  vec_t vecs[10];

  int unsigned n;
  logic        m_valid;
  logic        m_pending;

  initial begin
    // Enable with ready tied high: valid 2 edges after enable, then one sample per 2 edges.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,         7'd0, 3'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'hA000_1000, 7'd0, 3'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         7'd1, 3'd0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hA001_1001, 7'd1, 3'd0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,         7'd2, 3'd0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hA002_1002, 7'd2, 3'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0,         7'd3, 3'd0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hA003_1003, 7'd3, 3'd0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0,         7'd0, 3'd1, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 32'hA000_1000, 7'd0, 3'd1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_sample", sample, 32'h0);
    chk("reset_addr", 32'(rom_addr), 32'd0);
    chk("reset_wrap", 32'(wrap_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      en    = vecs[i].en;
      ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].vld));
      if (vecs[i].vld) chk($sformatf("vec%0d_sample", i), sample, vecs[i].smp);
      chk($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap_count), 32'(vecs[i].wrap));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Backpressure: ready low for 10 cycles while valid.
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_sample", sample, 32'hA000_1000);
      chk("bp_addr", 32'(rom_addr), 32'd0);
    end
    ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(valid), 32'd0);
    chk("bp_rel_addr", 32'(rom_addr), 32'd1);
    ready = 1'b0;
    tick();
    chk("bp_next_valid", 32'(valid), 32'd1);
    chk("bp_next_sample", sample, 32'hA001_1001);

    // Enable falls while a sample is pending: valid held until accepted.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_hold_valid", 32'(valid), 32'd1);
      chk("dis_hold_sample", sample, 32'hA001_1001);
      chk("dis_hold_busy", 32'(busy), 32'd1);
    end
    ready = 1'b1;
    tick();
    chk("dis_hs_valid", 32'(valid), 32'd0);
    chk("dis_hs_addr", 32'(rom_addr), 32'd2);
    chk("dis_hs_busy", 32'(busy), 32'd0);
    chk("dis_hs_wrap", 32'(wrap_count), 32'd1);
    ready = 1'b0;
    tick();
    chk("idle_stay_valid", 32'(valid), 32'd0);
    chk("idle_stay_busy", 32'(busy), 32'd0);
    chk("idle_stay_addr", 32'(rom_addr), 32'd2);
    en = 1'b1;
    tick();
    chk("reen_addr", 32'(rom_addr), 32'd0);
    chk("reen_wrap", 32'(wrap_count), 32'd0);
    chk("reen_busy", 32'(busy), 32'd1);
    chk("reen_valid", 32'(valid), 32'd0);
    tick();
    chk("reen_first_valid", 32'(valid), 32'd1);
    chk("reen_first_sample", sample, 32'hA000_1000);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(valid), 32'd1);
    chk("pre_rst_addr", 32'(rom_addr), 32'd1);

    // Asynchronous reset between edges clears outputs without a clock.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_sample", sample, 32'h0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wrap", 32'(wrap_count), 32'd0);
    @(negedge clk);

    // Randomized run with enable held: n accepted samples determine every expected output.
    rst       = 1'b0;
    en        = 1'b1;
    ready     = 1'($urandom_range(0, 1));
    @(posedge clk);
    n         = 0;
    m_valid   = 1'b0;
    m_pending = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", 32'(valid), 32'(m_valid));
      if (m_valid) chk("rnd_sample", sample, rom_word(n % Loop));
      chk("rnd_addr", 32'(rom_addr), n % Loop);
      chk("rnd_wrap", 32'(wrap_count), ((n / Loop) > WrapM) ? WrapM : (n / Loop));
      chk("rnd_busy", 32'(busy), 32'd1);
      ready     = 1'($urandom_range(0, 1));
      // Garble the ROM whenever the coming edge is not a fetch; it must be ignored.
      force_en  = !m_pending;
      force_val = $urandom;
      @(posedge clk);
      if (m_pending) begin
        m_valid   = 1'b1;
        m_pending = 1'b0;
      end else if (m_valid && ready) begin
        n++;
        m_valid   = 1'b0;
        m_pending = 1'b1;
      end
      @(negedge clk);
    end
    force_en = 1'b0;
    chk("rnd_saturated", 32'(wrap_count), WrapM);

`ifdef TONE_ROM_PLAYER_GAIN_EN
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    en        = 1'b1;
    ready     = 1'b0;
    force_en  = 1'b1;
    force_val = 32'h8000_4000;
    gain      = 4'd2;
    tick();
    tick();
    chk("gain_sample", sample, 32'hE000_1000);
    force_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_rom_player.md
Name: tone_rom_player

Overview:
- Address sequencer and sample streamer placed in front of the tone ROM on the I2S transmit path.
- Steps the ROM address, registers each returned 32-bit stereo word, and presents it to the I2S transmitter input with a valid/ready handshake.
- Wraps at a programmable last address so the tone loops continuously.
- Counts completed tone periods for software status.

Parameters:
- DATA_WIDTH, 32, ROM word width; upper half is left channel, lower half is right channel.
- ADDR_WIDTH, 7, ROM address width.
- LAST_ADDR, 127, final ROM index of one tone loop; wrap back to 0 after it; must be < 2**ADDR_WIDTH.
- WRAP_CNT_WIDTH, 16, width of the loop counter.

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; play the tone while high.
- rom_addr_o  out  ADDR_WIDTH  registered address to the tone ROM.
- rom_q_i  in  DATA_WIDTH  combinational ROM data for rom_addr_o.
- sample_o  out  DATA_WIDTH  registered stereo sample.
- sample_valid_o  out  1  sample_o holds a valid sample.
- sample_ready_i  in  1  downstream accepts sample_o when high together with valid.
- wrap_count_o  out  WRAP_CNT_WIDTH  number of completed loops; saturates at all-ones.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by system):
  - state IDLE
  - rom_addr_o 0, sample_o 0, sample_valid_o 0, wrap_count_o 0, busy_o 0.
  - Reset mid-operation drops valid immediately; there is no partial-handshake recovery.
- States: IDLE, FETCH, PRESENT.
- IDLE:
  - enable_i high at edge k: rom_addr_o<=0, wrap_count_o<=0, go to FETCH.
  - enable_i low: stay in IDLE.
- FETCH (exactly one cycle):
  - sample_o<=rom_q_i, sample_valid_o<=1, go to PRESENT.
  - First valid is visible after edge k+1, i.e. 2-cycle latency from enable.
- PRESENT:
  - Hold sample_o and sample_valid_o stable until sample_valid_o && sample_ready_i at edge m.
  - Valid never drops without a handshake, even if enable_i falls.
  - On handshake at edge m:
    - sample_valid_o<=0.
    - rom_addr_o<=(rom_addr_o==LAST_ADDR) ? 0 : rom_addr_o+1.
    - If rom_addr_o==LAST_ADDR, wrap_count_o increments; it saturates, no rollover.
    - enable_i high: go to FETCH, so the next valid appears after edge m+1.
    - enable_i low: go to IDLE; rom_addr_o still advances; wrap_count_o is held until the next enable.
- Throughput: at most one sample per 2 clocks. This is adequate because the sample rate is far below the clock.
- ready high while valid low has no effect.
- Addresses > LAST_ADDR are never issued.
- rom_q_i is sampled only in FETCH; changes at other times are ignored.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro: TONE_ROM_PLAYER_GAIN_EN.
- When defined:
  - Adds input gain_shift_i [3:0].
  - In FETCH, each 16-bit half of rom_q_i is arithmetic-right-shifted by gain_shift_i, with sign preserved, before being registered into sample_o.
  - gain_shift_i values 0..15 are valid; gain_shift_i is sampled only in FETCH.
- When not defined:
  - No gain_shift_i port.
  - sample_o = rom_q_i unmodified.

Test Plan:
- Bench ROM model: q = {16'hA000+addr, 16'h1000+addr}.
- Reset then enable_i=1 and sample_ready_i=1 constant:
  - first valid 2 cycles after enable with sample_o=32'hA000_1000;
  - then one sample every 2 cycles, addr 0,1,2…;
  - busy_o=1.
- Backpressure: hold sample_ready_i=0 for 10 cycles while valid:
  - sample_o and sample_valid_o stable throughout;
  - rom_addr_o does not change;
  - releasing ready advances to the next address.
- Wrap with LAST_ADDR=3, ready=1, run 9 samples:
  - addresses 0,1,2,3,0,1,2,3,0;
  - wrap_count_o reads 1 after the 4th handshake and 2 after the 8th.
- enable_i dropped while PRESENT with ready=0:
  - valid held;
  - after ready=1, one handshake, then IDLE and busy_o=0;
  - re-enable restarts at addr 0 with wrap_count_o=0.
- Async reset asserted mid-PRESENT between clock edges:
  - all outputs zero immediately without a clock edge.
- Gain option with TONE_ROM_PLAYER_GAIN_EN defined, ROM word 32'h8000_4000, gain_shift_i=2:
  - sample_o=32'hE000_1000.
